// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a 1024x8 dual-port RAM: port A writes from an upstream
// valid/ready stream, port B prefetches into a 2-entry register stage feeding the consumer.
module ram_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH-1:0] ram_address_a,
    output logic                  ram_write_enable_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic [ADDR_WIDTH-1:0] ram_address_b,
    output logic                  ram_write_enable_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      fetch_ptr;
    logic                  inflight;
    logic [1:0]            buf_count;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [DATA_WIDTH-1:0] buf_tail;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  fetch;
    logic [1:0]            cnt_after_pop;

    // Handshakes depend only on registered state, never on same-cycle consumer input
    assign full          = (level == PTR_W'(DEPTH));
    assign wr_ready      = !full;
    assign push          = wr_valid && wr_ready;
    assign rd_valid      = (buf_count != 2'd0);
    assign rd_data       = buf_head;
    assign pop           = rd_valid && rd_ready;
    assign cnt_after_pop = buf_count - 2'(pop);

    // Only fetch words whose write edge has passed, and only while the stage has room
    assign fetch = (fetch_ptr != wr_ptr) &&
                   ((3'(inflight) + 3'(cnt_after_pop)) < 3'd2);

    assign ram_write_enable_a = push;
    assign ram_address_a      = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_data_a         = wr_data;
    assign ram_address_b      = fetch_ptr[ADDR_WIDTH-1:0];
    assign ram_write_enable_b = 1'b0;
    assign ram_data_b         = '0;

    // Pointers, fetch tracking and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            fetch_ptr <= '0;
            inflight  <= 1'b0;
            level     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fetch) begin
                fetch_ptr <= fetch_ptr + PTR_W'(1);
            end
            inflight <= fetch;
            if (push && !pop) begin
                level <= level + PTR_W'(1);
            end else if (pop && !push) begin
                level <= level - PTR_W'(1);
            end
        end
    end

    // Output stage: pop shifts tail to head, then the arriving RAM word lands in the first free slot
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_count <= 2'd0;
            buf_head  <= '0;
            buf_tail  <= '0;
        end else begin
            if (pop) begin
                buf_head <= buf_tail;
            end
            if (inflight) begin
                if (cnt_after_pop == 2'd0) begin
                    buf_head <= ram_q_b;
                end else begin
                    buf_tail <= ram_q_b;
                end
            end
            buf_count <= cnt_after_pop + 2'(inflight);
        end
    end

endmodule
